tage_update_queue: RTL
======================

Name: tage_update_queue

Overview:
- Buffers resolved-branch outcomes from the execute/commit side and replays them, one per cycle, as training writes to the TAGE base predictor table.
- It is the writer-side counterpart of the table's read/predict port. It decouples bursty branch resolution from the table's single write port.
- It absorbs cycles where the table write port is unavailable, and drops all pending training on a pipeline flush.

Parameters:
- DEPTH, 8, number of queued resolution entries; power of two, minimum 2.
- PTR_W, $clog2(DEPTH), pointer width; derived, never overridden.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- res_valid  input  1  resolved branch presented.
- res_ready  output  1  queue can accept this cycle.
- res_pc  input  32  branch PC.
- res_ghr  input  2  global-history snapshot used at prediction time.
- res_taken  input  1  actual direction.
- res_pred  input  2  2-bit counter value read at prediction time.
- flush  input  1  discard all pending entries.
- upd_stall  input  1  table write port unavailable this cycle.
- upd_valid  output  1  training write issued this cycle.
- upd_pc  output  32  PC of issued entry.
- upd_ghr  output  2  history of issued entry.
- upd_taken  output  1  direction of issued entry.
- upd_pred  output  2  counter of issued entry.
- occupancy  output  PTR_W+1  entries currently held, 0..DEPTH.

Behaviour:
- Storage:
  - Circular buffer of DEPTH entries, each {pc[31:0], ghr[1:0], taken, pred[1:0]} = 37 bits.
  - Read and write pointers are PTR_W+1 bits; the extra MSB distinguishes full from empty.
  - empty when the pointers are equal.
  - full when the low bits are equal and the MSBs differ.
- Enqueue:
  - res_ready = !full && !flush && !rst.
  - Push occurs when res_valid && res_ready: entry written at the write pointer, pointer +1 (wraps modulo 2^(PTR_W+1)).
  - When full, res_ready is low even if a pop occurs that cycle; there is no pass-through while full.
- Dequeue:
  - upd_valid = !empty && !upd_stall && !flush && !rst.
  - upd_* are driven combinationally from the head entry whenever !empty. They are 0 when empty.
  - Pop occurs when upd_valid: read pointer +1.
- Latency:
  - An entry pushed in cycle N is at the head no earlier than N+1.
  - It is issued in N+1 if the queue was empty and upd_stall=0.
- Ordering:
  - Strict FIFO. No reordering or coalescing.
  - Duplicate PCs are issued as separate writes.
- Simultaneous push and pop (not full, not empty): both take effect; occupancy unchanged.
- upd_stall:
  - Holds the head entry; upd_valid=0.
  - Pushes continue until full.
  - The head is re-presented unchanged once the stall deasserts.
- flush:
  - In the flush cycle: no push, no pop, upd_valid=0.
  - Next edge: both pointers return to 0, so occupancy=0.
  - flush with the queue empty is harmless.
- occupancy equals write pointer minus read pointer (modulo 2^(PTR_W+1)); it is updated at the clock edge.
- Reset, synchronous:
  - Pointers cleared; occupancy=0.
  - While rst is high: res_ready=0, upd_valid=0, upd_*=0.
  - Storage contents are not reset.
  - A rst asserted mid-stream discards all entries, exactly like flush.

Optional Feature:
- Macro: TAGE_UPDQ_BYPASS_EN.
- Defined:
  - When the queue is empty, res_valid=1, upd_stall=0 and flush=0, the incoming resolution is issued the same cycle.
  - In that case upd_valid=1, upd_* = res_*, and nothing is written to storage.
  - res_ready is unaffected.
  - This gives zero-cycle latency for a lone resolution.
- Undefined: minimum latency is one cycle, as above.

Test Plan:
- Reset and idle:
  - Stimulus: assert rst 2 cycles with res_valid=1, then release with res_valid=0.
  - Required response: res_ready=0 and upd_valid=0 during reset; afterwards occupancy=0, upd_valid=0, res_ready=1.
- Single entry:
  - Stimulus: push pc=0x0000_1040, ghr=2'b10, taken=1, pred=2'b01 in cycle N.
  - Required response: upd_valid=1 in N+1 (N with BYPASS_EN) carrying the same fields; occupancy returns to 0.
- Fill under stall:
  - Stimulus: hold upd_stall=1 and push DEPTH+2 entries with pc=0x100+4*i.
  - Required response: res_ready drops after 8 accepted; occupancy=8.
  - Then release the stall: 8 writes on consecutive cycles, pc 0x100..0x11C in order, with no gaps.
- Concurrent push/pop with wrap:
  - Stimulus: stream 20 entries back-to-back with upd_stall=0.
  - Required response: occupancy stays ≤1; all 20 are issued in order across pointer wraps.
- Flush mid-stream:
  - Stimulus: with 5 queued entries, assert flush for 1 cycle while res_valid=1.
  - Required response: upd_valid=0 that cycle; occupancy=0 next cycle; the flush-cycle input is not accepted.
- Stall toggle at full:
  - Stimulus: queue full, upd_stall alternating 1/0 with res_valid=1.
  - Required response: one pop every other cycle; res_ready goes high only in the cycle after each pop; the head is never skipped or duplicated.

Source files
------------

// File: rtl/tage_update_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tage_update_queue
//  Description : FIFO of resolved-branch outcomes replayed one per cycle as
//                training writes to the TAGE base table. Optional same-cycle
//                bypass when empty: define TAGE_UPDQ_BYPASS_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module tage_update_queue #(
    parameter  int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             res_valid,
    output logic             res_ready,
    input  logic [31:0]      res_pc,
    input  logic [1:0]       res_ghr,
    input  logic             res_taken,
    input  logic [1:0]       res_pred,
    input  logic             flush,
    input  logic             upd_stall,
    output logic             upd_valid,
    output logic [31:0]      upd_pc,
    output logic [1:0]       upd_ghr,
    output logic             upd_taken,
    output logic [1:0]       upd_pred,
    output logic [PTR_W:0]   occupancy
);

    localparam int c_ENTRY_W = 37;

    logic [c_ENTRY_W-1:0] r_mem [DEPTH];
    logic [PTR_W:0]       r_wr_ptr;
    logic [PTR_W:0]       r_rd_ptr;

    logic                 w_empty;
    logic                 w_full;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_bypass;
    logic [c_ENTRY_W-1:0] w_head;
    logic [c_ENTRY_W-1:0] w_res_entry;
    logic [c_ENTRY_W-1:0] w_upd_entry;

    // Extra pointer MSB separates full (MSBs differ) from empty (all equal).
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]) &&
                     (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]);

    assign w_res_entry = {res_pc, res_ghr, res_taken, res_pred};
    assign w_head      = r_mem[r_rd_ptr[PTR_W-1:0]];

`ifdef TAGE_UPDQ_BYPASS_EN
    assign w_bypass = w_empty && res_valid && !upd_stall && !flush && !rst;
`else
    assign w_bypass = 1'b0;
`endif

    assign res_ready = !w_full && !flush && !rst;
    assign w_pop     = !w_empty && !upd_stall && !flush && !rst;
    // A bypassed resolution is consumed directly and never enters storage.
    assign w_push    = res_valid && res_ready && !w_bypass;
    assign upd_valid = w_pop || w_bypass;

    always_comb begin
        w_upd_entry = '0;
        if (!rst) begin
            if (!w_empty) begin
                w_upd_entry = w_head;
            end else if (w_bypass) begin
                w_upd_entry = w_res_entry;
            end
        end
    end

    assign {upd_pc, upd_ghr, upd_taken, upd_pred} = w_upd_entry;
    assign occupancy = r_wr_ptr - r_rd_ptr;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    // Storage is not reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[PTR_W-1:0]] <= w_res_entry;
        end
    end

endmodule
`default_nettype wire
